// File: rtl/dm_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_bus_bridge_pkg
// Purpose  : Shared types and constants for the data-memory bus bridge:
//            machine word width and the 3-bit load-sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dm_bus_bridge_pkg;

  // Machine word width; the bridge data path defaults to this.
  localparam int WORD_WIDTH = 32;

  // Load sequencer states. Stores never leave IDLE; only loads walk the chain.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,  // no load in progress, write buffer drains
    ST_RD_DRAIN = 3'd1,  // load waiting for older stores to leave the buffer
    ST_RD_REQ   = 3'd2,  // read request presented on the bus
    ST_RD_WAIT  = 3'd3,  // read accepted, waiting for response data
    ST_RD_DONE  = 3'd4   // one-cycle hand-back of load data to the pipeline
  } bridgeState_e;

  // States in which the write buffer head owns the bus request port.
  function automatic logic isDrainState(input bridgeState_e s);
    return (s == ST_IDLE) || (s == ST_RD_DRAIN);
  endfunction

endpackage : dm_bus_bridge_pkg
`default_nettype wire

// File: rtl/dm_bus_bridge_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous write-buffer FIFO for posted stores. Pointers carry
//            one extra wrap bit so full and empty are told apart without a
//            separate occupancy counter. Push while full and pop while empty
//            are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[IDX_W] != rdPtr[IDX_W]) &&
                 (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]);
  assign count = wrPtr - rdPtr;
  assign head  = mem[rdPtr[IDX_W-1:0]];

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Pointer update; reset discards every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
    end
  end

  // Entry storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[IDX_W-1:0]] <= pushData;
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/dm_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dm_bus_bridge
// Purpose  : Bridges the CPU MEM stage onto a variable-latency valid/ready
//            bus. Stores are posted into a write buffer at zero cost; loads
//            first drain the buffer, then issue a single bus read while the
//            pipeline is frozen through cpuStall.
// Revision : 1.0 - initial release
// ============================================================================
module dm_bus_bridge
  import dm_bus_bridge_pkg::*;
#(
  parameter int WB_DEPTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // CPU MEM-stage side
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWData,
  input  logic                  cpuWrite,
  input  logic                  cpuRead,
  output logic [DATA_WIDTH-1:0] cpuRData,
  output logic                  cpuStall,
  // Bus request channel
  output logic                  busReqValid,
  input  logic                  busReqReady,
  output logic                  busReqWrite,
  output logic [ADDR_WIDTH-1:0] busReqAddr,
  output logic [DATA_WIDTH-1:0] busReqWData,
  // Bus read-response channel
  input  logic                  busRespValid,
  input  logic [DATA_WIDTH-1:0] busRespData
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W   = $clog2(WB_DEPTH) + 1;

  bridgeState_e        state;

  logic                fifoFull;
  logic                fifoEmpty;
  logic [ENTRY_W-1:0]  fifoHead;
  logic [PTR_W-1:0]    fifoCount;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;

  logic                loadPending;
  logic                storePush;
  logic                drainValid;
  logic                drainPop;
  logic                lastPop;

  assign headAddr = fifoHead[ENTRY_W-1:DATA_WIDTH];
  assign headData = fifoHead[DATA_WIDTH-1:0];

  // Any load in flight (or arriving) blocks new stores; a store issued
  // together with a load is dropped and the access is treated as a load.
  assign loadPending = cpuRead || (state != ST_IDLE);

  // A store is only posted when a slot is free at the start of the cycle;
  // a slot freed by a same-cycle pop is not reused until the next cycle.
  assign storePush = cpuWrite && !fifoFull && !loadPending;

  assign drainValid = isDrainState(state) && !fifoEmpty;
  assign drainPop   = drainValid && busReqReady;
  assign lastPop    = drainPop && (fifoCount == PTR_W'(1));

  wb_fifo #(
    .DEPTH (WB_DEPTH),
    .WIDTH (ENTRY_W)
  ) uWbFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (storePush),
    .pushData ({cpuAddr, cpuWData}),
    .pop      (drainPop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (fifoHead),
    .count    (fifoCount)
  );

  // Freeze for a load until its data hand-back cycle, or for a store that
  // finds the buffer full. Forced low while reset is asserted.
  always_comb begin
    cpuStall = 1'b0;
    if (rst_n) begin
      cpuStall = (cpuRead && (state != ST_RD_DONE)) ||
                 (cpuWrite && !cpuRead && fifoFull);
    end
  end

  // Bus request mux: buffer head while draining, otherwise the pending read.
  // Both sources are held stable by construction until accepted: the head only
  // moves on a pop, and cpuAddr is frozen by cpuStall during RD_REQ.
  always_comb begin
    busReqValid = 1'b0;
    busReqWrite = 1'b0;
    busReqAddr  = '0;
    busReqWData = '0;
    if (drainValid) begin
      busReqValid = 1'b1;
      busReqWrite = 1'b1;
      busReqAddr  = headAddr;
      busReqWData = headData;
    end else if (state == ST_RD_REQ) begin
      busReqValid = 1'b1;
      busReqAddr  = cpuAddr;
    end
  end

  // Load sequencer and read-data capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cpuRData <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpuRead) begin
            state <= fifoEmpty ? ST_RD_REQ : ST_RD_DRAIN;
          end
        end
        ST_RD_DRAIN: begin
          // Empty check covers the case where the last entry left while
          // still in IDLE on the cycle the load arrived.
          if (lastPop || fifoEmpty) begin
            state <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (busReqReady) begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (busRespValid) begin
            cpuRData <= busRespData;
            state    <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: begin
          // The load is still on cpuRead this cycle; it must not reissue.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : dm_bus_bridge
`default_nettype wire
